count_bcd_ndigit: RTL

//   Multi-digit BCD up/down counter with parallel load and a debounced direction switch.

---
 rtl/count_bcd_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 47 ++++
 rtl/count_bcd_ndigit.sv | 132 +++++++++++++
 3 files changed

// File: rtl/count_bcd_pkg.sv
// Shared constants and the 7-segment decoder for the multi-digit BCD counter.
//   BCD_W   : width of one BCD digit
//   BCD_MAX : largest legal BCD digit value
//   seg7()  : BCD digit -> active-low segments {g,f,e,d,c,b,a}; codes above 9 are blanked
package count_bcd_pkg;

    localparam int unsigned BCD_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [6:0] seg7(input logic [BCD_W-1:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the counter chain.
//   clk, rst_a_n : clock, asynchronous active-low reset (digit clears to 0)
//   load, ld_val : synchronous load; values above 9 load as 0
//   inc, dec     : step this digit up/down on the clock edge (load has priority)
//   value        : registered digit value
//   carry_out    : inc while at 9   -> next digit must increment (combinational)
//   borrow_out   : dec while at 0   -> next digit must decrement (combinational)
module bcd_digit
    import count_bcd_pkg::*;
(
    input  logic             clk,
    input  logic             rst_a_n,
    input  logic             load,
    input  logic [BCD_W-1:0] ld_val,
    input  logic             inc,
    input  logic             dec,
    output logic [BCD_W-1:0] value,
    output logic             carry_out,
    output logic             borrow_out
);

    logic [BCD_W-1:0] value_d, value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (ld_val > BCD_MAX) ? '0 : ld_val;
        end else if (inc) begin
            value_d = (value_q == BCD_MAX) ? '0 : value_q + BCD_W'(1);
        end else if (dec) begin
            value_d = (value_q == '0) ? BCD_MAX : value_q - BCD_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value      = value_q;
    assign carry_out  = inc & (value_q == BCD_MAX);
    assign borrow_out = dec & (value_q == '0);

endmodule

// File: rtl/count_bcd_ndigit.sv
// Multi-digit BCD up/down counter with parallel load, enable, wrap flag and a debounced
// direction switch; one active-low 7-segment output per digit.
//   clk, rst_a_n : system clock, asynchronous active-low reset
//   up_down_in   : raw direction switch (1 = up), synchronised and debounced internally
//   en           : count enable; a tick seen with en=0 is lost
//   load,data_in : synchronous parallel load (priority over counting), digit 0 = LSD
//   bcd_out      : registered BCD count
//   wrap         : registered 1-cycle roll-over / roll-under pulse
//   disp_out     : combinational segment decode of bcd_out, digit k in [7k+6:7k]
// Build option: define COUNT_BCD_SAT_EN to saturate at all-9s / all-0s instead of wrapping;
// wrap then pulses once on the tick that first reaches the limit.
module count_bcd_ndigit
    import count_bcd_pkg::*;
#(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned TICK_DIV  = 50_000_000,
    parameter int unsigned DEB_N_MAX = 5000
) (
    input  logic                    clk,
    input  logic                    rst_a_n,
    input  logic                    up_down_in,
    input  logic                    en,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] data_in,
    output logic [BCD_W*DIGITS-1:0] bcd_out,
    output logic                    wrap,
    output logic [7*DIGITS-1:0]     disp_out
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = (DEB_N_MAX > 1) ? $clog2(DEB_N_MAX) : 1;

    // Prescaler: tick is a one-clk enable, not a clock
    logic [PW-1:0] presc_d, presc_q;
    logic          tick;

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
    end

    // Direction: two-flop synchroniser, then flip only after DEB_N_MAX consecutive
    // cycles of disagreement with the current debounced value
    logic [1:0]    sync_d, sync_q;
    logic [DW-1:0] deb_cnt_d, deb_cnt_q;
    logic          dir_d, dir_q;

    always_comb begin
        sync_d    = {sync_q[0], up_down_in};
        deb_cnt_d = '0;
        dir_d     = dir_q;
        if (sync_q[1] != dir_q) begin
            if (deb_cnt_q == DW'(DEB_N_MAX - 1)) begin
                dir_d = sync_q[1];
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    // Count request for the LSD; load suppresses counting on the same edge
    logic [BCD_W*DIGITS-1:0] bcd_val;
    logic                    cnt_up, cnt_dn;
    logic                    wrap_d, wrap_q;

`ifdef COUNT_BCD_SAT_EN
    localparam logic [BCD_W*DIGITS-1:0] ALL_NINES = {DIGITS{BCD_MAX}};
    localparam logic [BCD_W*DIGITS-1:0] NEAR_MAX  = ALL_NINES - 1'b1;
    localparam logic [BCD_W*DIGITS-1:0] NEAR_MIN  = {{(BCD_W*DIGITS-1){1'b0}}, 1'b1};

    always_comb begin
        cnt_up = tick & en & ~load & dir_q & (bcd_val != ALL_NINES);
        cnt_dn = tick & en & ~load & ~dir_q & (bcd_val != '0);
        // Pulse only on the step that lands on the limit
        wrap_d = (cnt_up & (bcd_val == NEAR_MAX)) | (cnt_dn & (bcd_val == NEAR_MIN));
    end
`else
    always_comb begin
        cnt_up = tick & en & ~load & dir_q;
        cnt_dn = tick & en & ~load & ~dir_q;
        // Carry/borrow rippling out of the MSD means the whole counter rolled
        wrap_d = g_digit[DIGITS-1].carry | g_digit[DIGITS-1].borrow;
    end
`endif

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic inc, dec, carry, borrow;

        if (k == 0) begin : g_lsd
            assign inc = cnt_up;
            assign dec = cnt_dn;
        end else begin : g_ripple
            assign inc = g_digit[k-1].carry;
            assign dec = g_digit[k-1].borrow;
        end

        bcd_digit u_digit (
            .clk        (clk),
            .rst_a_n    (rst_a_n),
            .load       (load),
            .ld_val     (data_in[BCD_W*k +: BCD_W]),
            .inc        (inc),
            .dec        (dec),
            .value      (bcd_val[BCD_W*k +: BCD_W]),
            .carry_out  (carry),
            .borrow_out (borrow)
        );

        assign disp_out[7*k +: 7] = seg7(bcd_val[BCD_W*k +: BCD_W]);
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            presc_q   <= '0;
            sync_q    <= '0;
            deb_cnt_q <= '0;
            dir_q     <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            sync_q    <= sync_d;
            deb_cnt_q <= deb_cnt_d;
            dir_q     <= dir_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bcd_out = bcd_val;
    assign wrap    = wrap_q;

endmodule
